hsv_convert_arbiter: RTL and testbench

- Shares one pipelined rgb2hsv converter (fixed LATENCY, no backpressure) between two pixel requesters, e.g. the camera stream and the colour-calibration sampler.
- Round-robin arbitrates valid/ready requests and drives the converter's input port.
- Carries a per-pixel requester ID and tag through a latency-matched delay line, then returns each HSV result with its ID and tag.
- Checks that converter hsv_valid stays aligned with the delay line.

---
 rtl/hsv_arb_pkg.sv | 11 +
 rtl/tag_delay_line.sv | 38 +++
 rtl/hsv_convert_arbiter.sv | 137 +++++++++++++
 tb/tb_hsv_convert_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hsv_arb_pkg.sv
// hsv_arb_pkg: shared types for the two-requester rgb2hsv converter arbiter
package hsv_arb_pkg;
  localparam int NUM_REQ = 2;
  localparam int TAG_W = 19;
  typedef logic req_id_t;
  typedef struct packed {
    logic             valid;
    req_id_t          id;
    logic [TAG_W-1:0] tag;
  } tag_stage_t;
endpackage

// File: rtl/tag_delay_line.sv
// tag_delay_line: LATENCY-stage shift register of {valid, id, tag}; only valid bits are reset
module tag_delay_line
  import hsv_arb_pkg::*;
#(
  parameter int LATENCY = 15
) (
  input  logic       clock,
  input  logic       reset,
  input  tag_stage_t in_stage,
  output tag_stage_t out_stage,
  output logic       any_valid
);
  logic [LATENCY-1:0] valid_q, valid_d;
  req_id_t            id_q  [LATENCY];
  req_id_t            id_d  [LATENCY];
  logic [TAG_W-1:0]   tag_q [LATENCY];
  logic [TAG_W-1:0]   tag_d [LATENCY];
  always_comb begin
    valid_d = (valid_q << 1) | LATENCY'(in_stage.valid);
    id_d[0] = in_stage.id;
    tag_d[0] = in_stage.tag;
    for (int i = 1; i < LATENCY; i++) begin
      id_d[i] = id_q[i-1];
      tag_d[i] = tag_q[i-1];
    end
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) valid_q <= '0;
    else valid_q <= valid_d;
  end
  // Payload is only consumed alongside its valid bit, so it needs no reset.
  always_ff @(posedge clock) begin
    id_q <= id_d;
    tag_q <= tag_d;
  end
  assign out_stage = '{valid: valid_q[LATENCY-1], id: id_q[LATENCY-1], tag: tag_q[LATENCY-1]};
  assign any_valid = |valid_q;
endmodule

// File: rtl/hsv_convert_arbiter.sv
// hsv_convert_arbiter: round-robin sharing of one fixed-latency rgb2hsv converter between two requesters
module hsv_convert_arbiter
  import hsv_arb_pkg::*;
#(
  parameter int RGB_WIDTH = 8,
  parameter int HSV_WIDTH = 8,
  parameter int TAG_WIDTH = 19,
  parameter int LATENCY   = 15
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [RGB_WIDTH-1:0] req0_r,
  input  logic [RGB_WIDTH-1:0] req0_g,
  input  logic [RGB_WIDTH-1:0] req0_b,
  input  logic [TAG_WIDTH-1:0] req0_tag,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [RGB_WIDTH-1:0] req1_r,
  input  logic [RGB_WIDTH-1:0] req1_g,
  input  logic [RGB_WIDTH-1:0] req1_b,
  input  logic [TAG_WIDTH-1:0] req1_tag,
  output logic                 rgb_inputs_valid,
  output logic [RGB_WIDTH-1:0] r,
  output logic [RGB_WIDTH-1:0] g,
  output logic [RGB_WIDTH-1:0] b,
  input  logic [HSV_WIDTH-1:0] h,
  input  logic [HSV_WIDTH-1:0] s,
  input  logic [HSV_WIDTH-1:0] v,
  input  logic                 hsv_valid,
  output logic                 res_valid,
  output logic                 res_id,
  output logic [HSV_WIDTH-1:0] res_h,
  output logic [HSV_WIDTH-1:0] res_s,
  output logic [HSV_WIDTH-1:0] res_v,
  output logic [TAG_WIDTH-1:0] res_tag,
  output logic                 busy,
  output logic                 sync_error
);
  localparam int BW = $clog2(LATENCY + 2);
  if (TAG_WIDTH != TAG_W || LATENCY < 1) begin : g_param_chk
    $error("hsv_convert_arbiter: TAG_WIDTH must equal TAG_W and LATENCY must be >= 1");
  end
  logic [NUM_REQ-1:0]   grant;
  req_id_t              last_q, last_d;
  logic                 iss_valid_q, iss_valid_d;
  req_id_t              iss_id_q, iss_id_d;
  logic [TAG_WIDTH-1:0] iss_tag_q, iss_tag_d;
  logic [RGB_WIDTH-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
  logic                 res_valid_q, res_valid_d;
  req_id_t              res_id_q, res_id_d;
  logic [HSV_WIDTH-1:0] res_h_q, res_h_d, res_s_q, res_s_d, res_v_q, res_v_d;
  logic [TAG_WIDTH-1:0] res_tag_q, res_tag_d;
  logic                 sync_q, sync_d;
  logic [BW-1:0]        blank_q, blank_d;
  tag_stage_t           iss_stage, dly;
  logic                 any_dly;
  tag_delay_line #(.LATENCY(LATENCY)) u_dly (
    .clock     (clock),
    .reset     (reset),
    .in_stage  (iss_stage),
    .out_stage (dly),
    .any_valid (any_dly)
  );
  // Grants are masked during reset so a waiting pixel is kept by its requester.
  always_comb begin
    grant[0] = !reset && req0_valid && (!req1_valid || last_q);
    grant[1] = !reset && req1_valid && (!req0_valid || !last_q);
    last_d = grant[0] ? 1'b0 : grant[1] ? 1'b1 : last_q;
    iss_valid_d = |grant;
    iss_id_d = grant[1];
    iss_tag_d = grant[0] ? req0_tag : grant[1] ? req1_tag : iss_tag_q;
    r_d = grant[0] ? req0_r : grant[1] ? req1_r : r_q;
    g_d = grant[0] ? req0_g : grant[1] ? req1_g : g_q;
    b_d = grant[0] ? req0_b : grant[1] ? req1_b : b_q;
    iss_stage = '{valid: iss_valid_q, id: iss_id_q, tag: iss_tag_q};
    res_valid_d = dly.valid;
    res_id_d = dly.valid ? dly.id : res_id_q;
    res_tag_d = dly.valid ? dly.tag : res_tag_q;
    res_h_d = dly.valid ? h : res_h_q;
    res_s_d = dly.valid ? s : res_s_q;
    res_v_d = dly.valid ? v : res_v_q;
    sync_d = sync_q || (blank_q == '0 && hsv_valid != dly.valid);
    blank_d = blank_q == '0 ? blank_q : blank_q - 1'b1;
  end
  // Blanking hides pixels that were inside the converter when reset hit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_q <= 1'b1;
      iss_valid_q <= 1'b0;
      iss_id_q <= 1'b0;
      iss_tag_q <= '0;
      r_q <= '0;
      g_q <= '0;
      b_q <= '0;
      res_valid_q <= 1'b0;
      res_id_q <= 1'b0;
      res_tag_q <= '0;
      res_h_q <= '0;
      res_s_q <= '0;
      res_v_q <= '0;
      sync_q <= 1'b0;
      blank_q <= BW'(LATENCY + 1);
    end else begin
      last_q <= last_d;
      iss_valid_q <= iss_valid_d;
      iss_id_q <= iss_id_d;
      iss_tag_q <= iss_tag_d;
      r_q <= r_d;
      g_q <= g_d;
      b_q <= b_d;
      res_valid_q <= res_valid_d;
      res_id_q <= res_id_d;
      res_tag_q <= res_tag_d;
      res_h_q <= res_h_d;
      res_s_q <= res_s_d;
      res_v_q <= res_v_d;
      sync_q <= sync_d;
      blank_q <= blank_d;
    end
  end
  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign rgb_inputs_valid = iss_valid_q;
  assign r = r_q;
  assign g = g_q;
  assign b = b_q;
  assign res_valid = res_valid_q;
  assign res_id = res_id_q;
  assign res_h = res_h_q;
  assign res_s = res_s_q;
  assign res_v = res_v_q;
  assign res_tag = res_tag_q;
  assign busy = iss_valid_q | any_dly;
  assign sync_error = sync_q;
endmodule

// File: tb/tb_hsv_convert_arbiter.sv
// tb_hsv_convert_arbiter: directed table and sequence checks against an echoing converter model
module tb_hsv_convert_arbiter;
  localparam int L = 15;
  logic clock = 0, reset = 1;
  always #5 clock = ~clock;
  logic req0_valid = 0, req0_ready, req1_valid = 0, req1_ready;
  logic [7:0] req0_r = 0, req0_g = 0, req0_b = 0, req1_r = 0, req1_g = 0, req1_b = 0;
  logic [18:0] req0_tag = 0, req1_tag = 0;
  logic rgb_inputs_valid, hsv_valid, res_valid, res_id, busy, sync_error;
  logic [7:0] r, g, b, h, s, v, res_h, res_s, res_v;
  logic [18:0] res_tag;

  hsv_convert_arbiter dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_r(req0_r), .req0_g(req0_g),
    .req0_b(req0_b), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_r(req1_r), .req1_g(req1_g),
    .req1_b(req1_b), .req1_tag(req1_tag),
    .rgb_inputs_valid(rgb_inputs_valid), .r(r), .g(g), .b(b),
    .h(h), .s(s), .v(v), .hsv_valid(hsv_valid),
    .res_valid(res_valid), .res_id(res_id), .res_h(res_h), .res_s(res_s), .res_v(res_v),
    .res_tag(res_tag), .busy(busy), .sync_error(sync_error)
  );

  // Converter model: echoes r/g/b as h/s/v after model_lat cycles, never reset.
  typedef struct packed { logic vl; logic [7:0] cr, cg, cb; } cv_t;
  cv_t pipe [32] = '{default: '0};
  int model_lat = L;
  always @(posedge clock) begin
    for (int i = 31; i > 0; i--) pipe[i] <= pipe[i-1];
    pipe[0] <= {rgb_inputs_valid, r, g, b};
  end
  assign hsv_valid = pipe[model_lat-1].vl;
  assign h = pipe[model_lat-1].cr;
  assign s = pipe[model_lat-1].cg;
  assign v = pipe[model_lat-1].cb;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0, failures = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] pr(input int t); logic [31:0] x; x = t; return x[7:0]; endfunction
  function automatic logic [7:0] pg(input int t); return pr(t) ^ 8'h55; endfunction
  function automatic logic [7:0] pb(input int t); return ~pr(t); endfunction

  task automatic set_raw(input int id, input logic vld, input logic [7:0] rr, input logic [7:0] gg,
                         input logic [7:0] bb, input logic [18:0] tg);
    if (id == 0) begin
      req0_valid = vld; req0_r = rr; req0_g = gg; req0_b = bb; req0_tag = tg;
    end else begin
      req1_valid = vld; req1_r = rr; req1_g = gg; req1_b = bb; req1_tag = tg;
    end
  endtask

  task automatic set_req(input int id, input logic vld, input int t);
    set_raw(id, vld, pr(t), pg(t), pb(t), 19'(t));
  endtask

  int g_log[$], exp_id[$], exp_tag[$], got_id[$], got_tag[$], got_cyc[$];
  logic [7:0] got_h[$], got_s[$], got_v[$];
  bit sync_seen;

  task automatic stream(input int n0, input int n1, input int tb0, input int tb1);
    int i0 = 0, i1 = 0, guard = 0;
    g_log.delete();
    while ((i0 < n0 || i1 < n1) && guard < 20) begin
      set_req(0, i0 < n0, tb0 + i0);
      set_req(1, i1 < n1, tb1 + i1);
      @(negedge clock);
      chk("one_grant", {31'b0, req0_ready & req1_ready}, 0);
      if (req0_ready) begin g_log.push_back(0); i0++; end
      if (req1_ready) begin g_log.push_back(1); i1++; end
      @(posedge clock); #1;
      guard++;
    end
    set_req(0, 0, 0);
    set_req(1, 0, 0);
    chk("stream_done", {31'b0, guard < 20}, 1);
  endtask

  task automatic collect(input int ncyc);
    got_id.delete(); got_tag.delete(); got_cyc.delete();
    got_h.delete(); got_s.delete(); got_v.delete();
    sync_seen = 0;
    repeat (ncyc) begin
      @(negedge clock);
      if (sync_error) sync_seen = 1;
      if (res_valid) begin
        got_id.push_back(int'(res_id)); got_tag.push_back(int'(res_tag)); got_cyc.push_back(cyc);
        got_h.push_back(res_h); got_s.push_back(res_s); got_v.push_back(res_v);
      end
    end
    @(posedge clock); #1;
  endtask

  task automatic check_stream(input string nm);
    chk({nm, "_grants"}, g_log.size(), exp_id.size());
    chk({nm, "_results"}, got_id.size(), exp_id.size());
    chk({nm, "_sync"}, {31'b0, sync_seen}, 0);
    for (int i = 0; i < exp_id.size(); i++) begin
      if (i < g_log.size()) chk({nm, "_grant_order"}, g_log[i], exp_id[i]);
      if (i < got_id.size()) begin
        chk({nm, "_res_id"}, got_id[i], exp_id[i]);
        chk({nm, "_res_tag"}, got_tag[i], exp_tag[i]);
        chk({nm, "_res_h"}, got_h[i], pr(exp_tag[i]));
        chk({nm, "_res_s"}, got_s[i], pg(exp_tag[i]));
        chk({nm, "_res_v"}, got_v[i], pb(exp_tag[i]));
        if (i > 0) chk({nm, "_no_bubble"}, got_cyc[i] - got_cyc[i-1], 1);
      end
    end
  endtask

  typedef struct {
    int id; logic [7:0] ir, ig, ib; logic [18:0] itag;
    logic [7:0] eh, es, ev; logic [18:0] etag;
  } vec_t;
  vec_t tbl [4];

  task automatic single(input vec_t vc);
    int lat = 0, busy_cnt = 0;
    bit got = 0;
    set_raw(vc.id, 1, vc.ir, vc.ig, vc.ib, vc.itag);
    @(negedge clock);
    chk("single_ready", {31'b0, vc.id == 0 ? req0_ready : req1_ready}, 1);
    chk("single_other_ready", {31'b0, vc.id == 0 ? req1_ready : req0_ready}, 0);
    @(posedge clock); #1;
    set_raw(vc.id, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 25; k++) begin
      @(negedge clock);
      if (k == 1) begin
        chk("issue_valid", {31'b0, rgb_inputs_valid}, 1);
        chk("issue_rgb", {8'b0, r, g, b}, {8'b0, vc.ir, vc.ig, vc.ib});
      end
      if (busy) busy_cnt++;
      if (res_valid && !got) begin
        got = 1; lat = k;
        chk("single_hsv", {8'b0, res_h, res_s, res_v}, {8'b0, vc.eh, vc.es, vc.ev});
        chk("single_id", {31'b0, res_id}, vc.id);
        chk("single_tag", {13'b0, res_tag}, {13'b0, vc.etag});
      end
    end
    chk("single_latency", lat, L + 2);
    chk("single_busy_cycles", busy_cnt, L + 1);
    @(posedge clock); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int gc;
    bit iv_seen, rv_seen, busy_seen;
    tbl[0] = '{0, 8'd255, 8'd255, 8'd255, 19'd5, 8'd255, 8'd255, 8'd255, 19'd5};
    tbl[1] = '{1, 8'h00, 8'h00, 8'h00, 19'h7ffff, 8'h00, 8'h00, 8'h00, 19'h7ffff};
    tbl[2] = '{0, 8'h12, 8'h34, 8'h56, 19'h40000, 8'h12, 8'h34, 8'h56, 19'h40000};
    tbl[3] = '{1, 8'h80, 8'h01, 8'hfe, 19'd307199, 8'h80, 8'h01, 8'hfe, 19'd307199};

    // Reset state, with a request pending that must not be accepted.
    req0_valid = 1;
    repeat (2) @(negedge clock);
    chk("rst_ready", {31'b0, req0_ready}, 0);
    chk("rst_issue", {31'b0, rgb_inputs_valid}, 0);
    chk("rst_rgb", {8'b0, r, g, b}, 0);
    chk("rst_res_valid", {31'b0, res_valid}, 0);
    chk("rst_res", {7'b0, res_id, res_h, res_s, res_v}, 0);
    chk("rst_res_tag", {13'b0, res_tag}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_sync", {31'b0, sync_error}, 0);
    req0_valid = 0;
    @(posedge clock); #1;
    reset = 0;

    // Idle.
    iv_seen = 0; rv_seen = 0; busy_seen = 0;
    repeat (40) begin
      @(negedge clock);
      iv_seen |= rgb_inputs_valid; rv_seen |= res_valid; busy_seen |= busy;
    end
    chk("idle_issue", {31'b0, iv_seen}, 0);
    chk("idle_res", {31'b0, rv_seen}, 0);
    chk("idle_busy", {31'b0, busy_seen}, 0);
    @(posedge clock); #1;

    // Continuous contention: first grant to requester 0, then strict alternation.
    exp_id = '{0, 1, 0, 1, 0, 1};
    exp_tag = '{0, 0, 1, 1, 2, 2};
    stream(3, 3, 0, 0);
    collect(30);
    check_stream("contend");

    for (int i = 0; i < 4; i++) single(tbl[i]);

    // Requester 1 waits one cycle with data held; accepted exactly once.
    exp_id = '{0, 1, 0};
    exp_tag = '{10, 50, 11};
    stream(2, 1, 10, 50);
    collect(30);
    check_stream("hold");

    // Converter one cycle early.
    model_lat = L - 1;
    set_req(0, 1, 77);
    @(negedge clock);
    chk("mis_ready", {31'b0, req0_ready}, 1);
    @(posedge clock); #1;
    set_req(0, 0, 0);
    for (int k = 1; k <= 22; k++) begin
      @(negedge clock);
      if (k == L) chk("mis_sync_before", {31'b0, sync_error}, 0);
      if (k == L + 1) begin
        chk("mis_sync_set", {31'b0, sync_error}, 1);
        chk("mis_spurious_res", {31'b0, res_valid}, 0);
      end
      if (k == 22) chk("mis_sync_sticky", {31'b0, sync_error}, 1);
    end
    @(posedge clock); #1;
    repeat (25) @(posedge clock);
    #1;
    model_lat = L;

    // Reset with pixels in flight; requester 1 keeps its pending pixel.
    stream(5, 0, 300, 0);
    reset = 1;
    set_req(1, 1, 400);
    repeat (2) begin
      @(negedge clock);
      chk("midrst_ready", {31'b0, req1_ready}, 0);
      chk("midrst_outs", {28'b0, rgb_inputs_valid, res_valid, busy, sync_error}, 0);
      chk("midrst_data", {5'b0, r, res_tag}, 0);
      @(posedge clock); #1;
    end
    reset = 0;
    @(negedge clock);
    chk("post_rst_grant", {31'b0, req1_ready}, 1);
    gc = cyc;
    @(posedge clock); #1;
    set_req(1, 0, 0);
    collect(40);
    chk("post_rst_results", got_id.size(), 1);
    chk("post_rst_sync", {31'b0, sync_seen}, 0);
    if (got_id.size() >= 1) begin
      chk("post_rst_id", got_id[0], 1);
      chk("post_rst_tag", got_tag[0], 400);
      chk("post_rst_h", got_h[0], pr(400));
      chk("post_rst_latency", got_cyc[0] - gc, L + 2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
